// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C register transaction sequencer.
package i2c_seq_pkg;

  localparam int unsigned CMD_W   = 16;
  localparam int unsigned STOP_B  = 4;
  localparam int unsigned ACK_B   = 3;
  localparam int unsigned START_B = 2;
  localparam int unsigned WR_B    = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_DONE,
    S_WAIT_IDLE,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_NACK    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } rsp_err_t;

  // Assemble one engine byte command word.
  function automatic logic [CMD_W-1:0] mk_cmd(input logic [7:0] data, input logic start,
                                              input logic ack, input logic stop, input logic wr);
    logic [CMD_W-1:0] c;
    c          = '0;
    c[15:8]    = data;
    c[STOP_B]  = stop;
    c[ACK_B]   = ack;
    c[START_B] = start;
    c[WR_B]    = wr;
    return c;
  endfunction

endpackage

// File: rtl/i2c_sclk_gen.sv
// Free-running bit-period phase counter producing the engine timing strobes.
module i2c_sclk_gen #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic clk,
  input  logic reset,
  output logic ctrl_sclk,
  output logic ctrl_sclk_en
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam int unsigned LO = CLK_DIV / 4;
  localparam int unsigned HI = (3 * CLK_DIV) / 4;

  logic [PW-1:0] r_phase;
  logic [PW-1:0] w_phase_nxt;
  logic          r_sclk;
  logic          r_sclk_en;

  // Wrap the phase at CLK_DIV-1.
  always_comb begin
    w_phase_nxt = r_phase + PW'(1);
    if (r_phase == PW'(CLK_DIV - 1)) w_phase_nxt = '0;
  end

  // Strobes are registered copies of the next phase decode so they track r_phase exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase   <= '0;
      r_sclk_en <= 1'b1;
      r_sclk    <= 1'b0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_sclk_en <= (w_phase_nxt == '0);
      r_sclk    <= (w_phase_nxt >= PW'(LO)) && (w_phase_nxt < PW'(HI));
    end
  end

  assign ctrl_sclk    = r_sclk;
  assign ctrl_sclk_en = r_sclk_en;

endmodule

// File: rtl/i2c_xact_seq.sv
// Register-level I2C sequencer: splits read/write requests into engine byte commands.
module i2c_xact_seq
  import i2c_seq_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 250,
  parameter int unsigned TIMEOUT_TICKS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rd,
  input  logic [6:0]        req_dev_addr,
  input  logic [7:0]        req_reg_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              ctrl_sclk,
  output logic              ctrl_sclk_en,
  output logic              st_trigger,
  output logic [CMD_W-1:0]  wr_data_in,
  output logic              ack_err_clr,
  input  logic              trans_done,
  input  logic              busy_flag,
  input  logic              ack_err,
  input  logic              rd_data_out_en,
  input  logic [7:0]        rd_data_out
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_TICKS + 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic             r_rd;
  logic [6:0]       r_dev;
  logic [7:0]       r_reg, r_wdata, r_rd_cap;
  logic [WD_W-1:0]  r_wd;
  logic             r_req_ready, r_st_trigger, r_ack_err_clr, r_rsp_valid;
  logic [7:0]       r_rsp_rdata;
  rsp_err_t         r_rsp_err, w_err_code;
  logic [CMD_W-1:0] r_wr_data, w_cmd_nxt;
  logic             w_accept, w_active, w_timeout, w_last, w_sclk, w_sclk_en;
  logic             w_rd;
  logic [6:0]       w_dev;
  logic [7:0]       w_reg, w_wdata;

  i2c_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk          (clk),
    .reset        (reset),
    .ctrl_sclk    (w_sclk),
    .ctrl_sclk_en (w_sclk_en)
  );

  assign w_active  = (r_state == S_LOAD) || (r_state == S_WAIT_DONE) || (r_state == S_WAIT_IDLE);
  assign w_timeout = w_active && (r_wd >= WD_W'(TIMEOUT_TICKS));
  assign w_last    = (r_idx == (r_rd ? 2'd3 : 2'd2));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state, byte index and response code.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_err_code  = ERR_OK;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_req_ready && req_valid) begin
          w_accept    = 1'b1;
          w_idx_nxt   = 2'd0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_timeout) begin
          w_err_code  = ERR_TIMEOUT;
          w_state_nxt = S_RESP;
        end else if (busy_flag) begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (w_timeout) begin
          w_err_code  = ERR_TIMEOUT;
          w_state_nxt = S_RESP;
        end else if (trans_done) begin
          w_state_nxt = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (w_timeout) begin
          w_err_code  = ERR_TIMEOUT;
          w_state_nxt = S_RESP;
        end else if (!busy_flag) begin
          // The engine has already issued STOP after a NACKed write byte.
          if (ack_err && r_wr_data[WR_B]) begin
            w_err_code  = ERR_NACK;
            w_state_nxt = S_RESP;
          end else if (w_last) begin
            w_state_nxt = S_RESP;
          end else begin
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request fields as seen by the command builder (live on the accept cycle).
  assign w_rd    = w_accept ? req_rd       : r_rd;
  assign w_dev   = w_accept ? req_dev_addr : r_dev;
  assign w_reg   = w_accept ? req_reg_addr : r_reg;
  assign w_wdata = w_accept ? req_wdata    : r_wdata;

  // Byte list: write = dev/reg/data, read = dev/reg/dev+R/data-in with master NACK.
  always_comb begin
    w_cmd_nxt = '0;
    case (w_idx_nxt)
      2'd0:    w_cmd_nxt = mk_cmd({w_dev, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b1);
      2'd1:    w_cmd_nxt = mk_cmd(w_reg, 1'b0, 1'b1, 1'b0, 1'b1);
      2'd2:    w_cmd_nxt = w_rd ? mk_cmd({w_dev, 1'b1}, 1'b1, 1'b1, 1'b0, 1'b1)
                                : mk_cmd(w_wdata, 1'b0, 1'b1, 1'b1, 1'b1);
      default: w_cmd_nxt = mk_cmd(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endcase
  end

  // Request latch, byte index, read-data capture and per-byte watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd     <= 1'b0;
      r_dev    <= '0;
      r_reg    <= '0;
      r_wdata  <= '0;
      r_idx    <= '0;
      r_rd_cap <= '0;
      r_wd     <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      if (w_accept) begin
        r_rd    <= req_rd;
        r_dev   <= req_dev_addr;
        r_reg   <= req_reg_addr;
        r_wdata <= req_wdata;
      end
      if (w_accept)            r_rd_cap <= '0;
      else if (rd_data_out_en) r_rd_cap <= rd_data_out;
      if ((w_state_nxt == S_LOAD) && (r_state != S_LOAD)) r_wd <= '0;
      else if (w_active && w_sclk_en && !w_timeout)        r_wd <= r_wd + WD_W'(1);
    end
  end

  // Registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_ready   <= 1'b0;
      r_st_trigger  <= 1'b0;
      r_ack_err_clr <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= ERR_OK;
      r_wr_data     <= '0;
    end else begin
      r_req_ready   <= (w_state_nxt == S_IDLE);
      r_st_trigger  <= (w_state_nxt == S_LOAD);
      r_ack_err_clr <= w_accept;
      r_rsp_valid   <= (w_state_nxt == S_RESP);
      if (w_state_nxt == S_LOAD) r_wr_data <= w_cmd_nxt;
      if (w_state_nxt == S_RESP) begin
        r_rsp_err   <= w_err_code;
        r_rsp_rdata <= (r_rd && (w_err_code == ERR_OK))
                       ? (rd_data_out_en ? rd_data_out : r_rd_cap) : 8'h00;
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign st_trigger   = r_st_trigger;
  assign ack_err_clr  = r_ack_err_clr;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_err      = r_rsp_err;
  assign wr_data_in   = r_wr_data;
  assign ctrl_sclk    = w_sclk;
  assign ctrl_sclk_en = w_sclk_en;

endmodule

// File: tb/tb_i2c_xact_seq.sv
// Bench for i2c_xact_seq with a simple engine/slave model and response/command scoreboards.
module tb_i2c_xact_seq;

  logic        clk, reset;
  logic        req_valid, req_ready, req_rd;
  logic [6:0]  req_dev_addr;
  logic [7:0]  req_reg_addr, req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_err;
  logic        ctrl_sclk, ctrl_sclk_en, st_trigger, ack_err_clr;
  logic [15:0] wr_data_in;
  logic        trans_done, busy_flag, ack_err, rd_data_out_en;
  logic [7:0]  rd_data_out;

  typedef struct packed {
    logic [7:0] rdata;
    logic [1:0] err;
  } rsp_t;

  rsp_t        exp_rsp_q[$];
  logic [15:0] exp_cmd_q[$];
  logic [15:0] got_cmd_q[$];

  int          n_tests = 0;
  int          n_fail  = 0;

  int          eng_cnt;
  logic [15:0] eng_cmd;
  logic        eng_stuck = 1'b0;
  logic        eng_nack  = 1'b0;
  logic [7:0]  slave_rdata = 8'h00;

  i2c_xact_seq #(.CLK_DIV(8), .TIMEOUT_TICKS(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_rd         (req_rd),
    .req_dev_addr   (req_dev_addr),
    .req_reg_addr   (req_reg_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .ctrl_sclk      (ctrl_sclk),
    .ctrl_sclk_en   (ctrl_sclk_en),
    .st_trigger     (st_trigger),
    .wr_data_in     (wr_data_in),
    .ack_err_clr    (ack_err_clr),
    .trans_done     (trans_done),
    .busy_flag      (busy_flag),
    .ack_err        (ack_err),
    .rd_data_out_en (rd_data_out_en),
    .rd_data_out    (rd_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine + slave model, driven on the falling edge.
  initial begin
    busy_flag = 0; trans_done = 0; ack_err = 0; rd_data_out_en = 0; rd_data_out = 0;
    eng_cnt = 0; eng_cmd = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_flag = 0; trans_done = 0; rd_data_out_en = 0; ack_err = 0; eng_cnt = 0;
      end else begin
        trans_done = 0; rd_data_out_en = 0;
        if (ack_err_clr) ack_err = 0;
        if (eng_cnt == 0) begin
          if (st_trigger && !eng_stuck) begin
            eng_cmd = wr_data_in;
            got_cmd_q.push_back(eng_cmd);
            busy_flag = 1;
            eng_cnt = 1;
          end
        end else begin
          eng_cnt++;
          if (eng_cnt == 4) begin
            trans_done = 1;
            if (eng_nack && eng_cmd[1] && eng_cmd[2]) ack_err = 1;
          end
          if (eng_cnt == 6 && !eng_cmd[1]) begin
            rd_data_out = slave_rdata;
            rd_data_out_en = 1;
          end
          if (eng_cnt == 8) begin
            busy_flag = 0;
            eng_cnt = 0;
          end
        end
      end
    end
  end

  // Expected command words for a request.
  task automatic push_cmds(input logic rd, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd);
    exp_cmd_q.push_back({dev, 1'b0, 8'h0E});
    exp_cmd_q.push_back({ra, 8'h0A});
    if (rd) begin
      exp_cmd_q.push_back({dev, 1'b1, 8'h0E});
      exp_cmd_q.push_back(16'h0010);
    end else begin
      exp_cmd_q.push_back({wd, 8'h1A});
    end
  endtask

  // Present a request until accepted; returns the strobes seen on the cycle after accept.
  task automatic drive_req(input logic rd, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd, output logic clr, output logic trig);
    int n;
    @(negedge clk);
    req_rd = rd; req_dev_addr = dev; req_reg_addr = ra; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (!req_ready) begin
      $display("FAIL req_accept: req_ready=%0b required 1 within 1000 cycles", req_ready);
      n_fail++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    clr  = ack_err_clr;
    trig = st_trigger;
  endtask

  // Wait (bounded) for the response pulse.
  task automatic wait_rsp(input int limit, output logic got, output logic [7:0] rd,
                          output logic [1:0] er, output logic trig, output int cyc);
    got = 0; rd = 0; er = 0; trig = 0; cyc = 0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        got = 1; rd = rsp_rdata; er = rsp_err; trig = st_trigger;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; req_valid = 1'b0; req_rd = 0; req_dev_addr = 0; req_reg_addr = 0; req_wdata = 0;
    repeat (3) @(negedge clk);
    v = {req_ready, st_trigger, ack_err_clr, rsp_valid, rsp_err, rsp_rdata, wr_data_in,
         ctrl_sclk, ctrl_sclk_en};
    n_tests++;
    if (v !== 32'h0000_0001) begin
      $display("FAIL reset_outputs: got %h required %h", v, 32'h0000_0001); n_fail++;
    end
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      n_tests++;
      if ({ctrl_sclk_en, ctrl_sclk} !== {(k % 8) == 0, ((k % 8) >= 2) && ((k % 8) < 6)}) begin
        $display("FAIL sclk_phase%0d: en/sclk=%b%b required %b%b", k, ctrl_sclk_en, ctrl_sclk,
                 (k % 8) == 0, ((k % 8) >= 2) && ((k % 8) < 6));
        n_fail++;
      end
      if (k == 1) begin
        n_tests++;
        if (req_ready !== 1'b1) begin
          $display("FAIL ready_after_reset: req_ready=%0b required 1", req_ready); n_fail++;
        end
      end
    end
  endtask

  task automatic test_write();
    logic clr, trig, got; logic [7:0] rd; logic [1:0] er; int cyc; rsp_t e; logic [15:0] ec, gc;
    exp_cmd_q.push_back(16'hA00E); exp_cmd_q.push_back(16'h100A); exp_cmd_q.push_back(16'hA51A);
    exp_rsp_q.push_back(rsp_t'({8'h00, 2'b00}));
    drive_req(1'b0, 7'h50, 8'h10, 8'hA5, clr, trig);
    n_tests++;
    if ({clr, trig} !== 2'b11) begin
      $display("FAIL write_start: clr/trig=%b required 11", {clr, trig}); n_fail++;
    end
    @(negedge clk);
    n_tests++;
    if (ack_err_clr !== 1'b0) begin
      $display("FAIL write_clr_pulse: ack_err_clr=%0b required 0", ack_err_clr); n_fail++;
    end
    wait_rsp(300, got, rd, er, trig, cyc);
    e = exp_rsp_q.pop_front();
    n_tests++;
    if (!got) begin $display("FAIL write_rsp: rsp_valid=0 required 1 within 300 cycles"); n_fail++; end
    n_tests++;
    if ({rd, er} !== e) begin
      $display("FAIL write_rsp_data: rdata/err=%h/%b required %h/%b", rd, er, e.rdata, e.err); n_fail++;
    end
    while (exp_cmd_q.size() > 0) begin
      ec = exp_cmd_q.pop_front(); gc = 16'hxxxx;
      if (got_cmd_q.size() > 0) gc = got_cmd_q.pop_front();
      n_tests++;
      if (gc !== ec) begin $display("FAIL write_cmd: wr_data_in=%h required %h", gc, ec); n_fail++; end
    end
    n_tests++;
    if (got_cmd_q.size() != 0) begin
      $display("FAIL write_extra_cmds: count=%0d required 0", got_cmd_q.size()); n_fail++;
      got_cmd_q.delete();
    end
  endtask

  task automatic test_read();
    logic clr, trig, got; logic [7:0] rd; logic [1:0] er; int cyc; rsp_t e; logic [15:0] ec, gc;
    slave_rdata = 8'h3C;
    exp_cmd_q.push_back(16'hA00E); exp_cmd_q.push_back(16'h100A);
    exp_cmd_q.push_back(16'hA10E); exp_cmd_q.push_back(16'h0010);
    exp_rsp_q.push_back(rsp_t'({8'h3C, 2'b00}));
    drive_req(1'b1, 7'h50, 8'h10, 8'h00, clr, trig);
    wait_rsp(300, got, rd, er, trig, cyc);
    e = exp_rsp_q.pop_front();
    n_tests++;
    if (!got) begin $display("FAIL read_rsp: rsp_valid=0 required 1 within 300 cycles"); n_fail++; end
    n_tests++;
    if ({rd, er} !== e) begin
      $display("FAIL read_rsp_data: rdata/err=%h/%b required %h/%b", rd, er, e.rdata, e.err); n_fail++;
    end
    while (exp_cmd_q.size() > 0) begin
      ec = exp_cmd_q.pop_front(); gc = 16'hxxxx;
      if (got_cmd_q.size() > 0) gc = got_cmd_q.pop_front();
      n_tests++;
      if (gc !== ec) begin $display("FAIL read_cmd: wr_data_in=%h required %h", gc, ec); n_fail++; end
    end
    n_tests++;
    if (got_cmd_q.size() != 0) begin
      $display("FAIL read_extra_cmds: count=%0d required 0", got_cmd_q.size()); n_fail++;
      got_cmd_q.delete();
    end
  endtask

  task automatic test_nack();
    logic clr, trig, got; logic [7:0] rd; logic [1:0] er; int cyc; rsp_t e; logic [15:0] ec, gc;
    // Address byte of a read is NACKed; stale read data must not leak out.
    eng_nack = 1'b1; slave_rdata = 8'h77;
    exp_cmd_q.push_back(16'hA00E);
    exp_rsp_q.push_back(rsp_t'({8'h00, 2'b01}));
    drive_req(1'b1, 7'h50, 8'h10, 8'h00, clr, trig);
    wait_rsp(300, got, rd, er, trig, cyc);
    eng_nack = 1'b0;
    // Follow-up write must run normally (sticky ack_err cleared by the new request).
    push_cmds(1'b0, 7'h22, 8'h33, 8'h44);
    exp_rsp_q.push_back(rsp_t'({8'h00, 2'b00}));
    e = exp_rsp_q.pop_front();
    n_tests++;
    if (!got) begin $display("FAIL nack_rsp: rsp_valid=0 required 1 within 300 cycles"); n_fail++; end
    n_tests++;
    if ({rd, er} !== e) begin
      $display("FAIL nack_rsp_data: rdata/err=%h/%b required %h/%b", rd, er, e.rdata, e.err); n_fail++;
    end
    n_tests++;
    if (got_cmd_q.size() != 1) begin
      $display("FAIL nack_byte_count: count=%0d required 1", got_cmd_q.size()); n_fail++;
    end
    drive_req(1'b0, 7'h22, 8'h33, 8'h44, clr, trig);
    wait_rsp(300, got, rd, er, trig, cyc);
    e = exp_rsp_q.pop_front();
    n_tests++;
    if (!got || {rd, er} !== e) begin
      $display("FAIL nack_followup: valid/rdata/err=%0b/%h/%b required 1/%h/%b", got, rd, er,
               e.rdata, e.err);
      n_fail++;
    end
    while (exp_cmd_q.size() > 0) begin
      ec = exp_cmd_q.pop_front(); gc = 16'hxxxx;
      if (got_cmd_q.size() > 0) gc = got_cmd_q.pop_front();
      n_tests++;
      if (gc !== ec) begin $display("FAIL nack_cmd: wr_data_in=%h required %h", gc, ec); n_fail++; end
    end
    got_cmd_q.delete();
  endtask

  task automatic test_timeout();
    logic clr, trig, got; logic [7:0] rd; logic [1:0] er; int cyc; rsp_t e;
    eng_stuck = 1'b1;
    exp_rsp_q.push_back(rsp_t'({8'h00, 2'b10}));
    drive_req(1'b0, 7'h11, 8'h22, 8'h33, clr, trig);
    n_tests++;
    if (trig !== 1'b1) begin $display("FAIL timeout_trig_start: st_trigger=%0b required 1", trig); n_fail++; end
    wait_rsp(2000, got, rd, er, trig, cyc);
    e = exp_rsp_q.pop_front();
    n_tests++;
    if (!got) begin $display("FAIL timeout_rsp: rsp_valid=0 required 1 within 2000 cycles"); n_fail++; end
    n_tests++;
    if ({rd, er} !== e || trig !== 1'b0) begin
      $display("FAIL timeout_rsp_data: rdata/err/trig=%h/%b/%0b required %h/%b/0", rd, er, trig,
               e.rdata, e.err);
      n_fail++;
    end
    n_tests++;
    if (cyc < 500 || cyc > 520) begin
      $display("FAIL timeout_latency: cycles=%0d required 500..520", cyc); n_fail++;
    end
    eng_stuck = 1'b0;
    got_cmd_q.delete();
  endtask

  task automatic test_reset_mid();
    logic clr, trig, got; logic [7:0] rd; logic [1:0] er; int cyc, n; rsp_t e; logic [31:0] v;
    logic [15:0] ec, gc;
    push_cmds(1'b0, 7'h50, 8'h10, 8'h5A);
    drive_req(1'b0, 7'h50, 8'h10, 8'h5A, clr, trig);
    n = 0;
    while (got_cmd_q.size() < 2 && n < 200) begin @(negedge clk); n++; end
    n_tests++;
    if (got_cmd_q.size() < 2) begin
      $display("FAIL mid_second_byte: bytes=%0d required 2", got_cmd_q.size()); n_fail++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    v = {req_ready, st_trigger, ack_err_clr, rsp_valid, rsp_err, rsp_rdata, wr_data_in,
         ctrl_sclk, ctrl_sclk_en};
    n_tests++;
    if (v !== 32'h0000_0001) begin
      $display("FAIL mid_reset_outputs: got %h required %h", v, 32'h0000_0001); n_fail++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_cmd_q.delete(); got_cmd_q.delete(); exp_rsp_q.delete();
    push_cmds(1'b0, 7'h3A, 8'hC3, 8'h96);
    exp_rsp_q.push_back(rsp_t'({8'h00, 2'b00}));
    drive_req(1'b0, 7'h3A, 8'hC3, 8'h96, clr, trig);
    wait_rsp(300, got, rd, er, trig, cyc);
    e = exp_rsp_q.pop_front();
    n_tests++;
    if (!got || {rd, er} !== e) begin
      $display("FAIL mid_after_reset: valid/rdata/err=%0b/%h/%b required 1/%h/%b", got, rd, er,
               e.rdata, e.err);
      n_fail++;
    end
    while (exp_cmd_q.size() > 0) begin
      ec = exp_cmd_q.pop_front(); gc = 16'hxxxx;
      if (got_cmd_q.size() > 0) gc = got_cmd_q.pop_front();
      n_tests++;
      if (gc !== ec) begin $display("FAIL mid_cmd: wr_data_in=%h required %h", gc, ec); n_fail++; end
    end
    got_cmd_q.delete();
  endtask

  task automatic test_back_to_back();
    logic got, trig; logic [7:0] rd; logic [1:0] er; int cyc; rsp_t e; logic [15:0] ec, gc;
    logic [6:0] d2; logic [7:0] r1, r2, w2, s1, s2;
    r1 = 8'($urandom); r2 = 8'($urandom); w2 = 8'($urandom); d2 = 7'($urandom);
    s1 = 8'($urandom); s2 = 8'($urandom);
    slave_rdata = s1;
    push_cmds(1'b1, 7'h2B, r1, 8'h00);
    exp_rsp_q.push_back(rsp_t'({s1, 2'b00}));
    @(negedge clk);
    req_rd = 1'b1; req_dev_addr = 7'h2B; req_reg_addr = r1; req_wdata = 8'h00; req_valid = 1'b1;
    wait_rsp(400, got, rd, er, trig, cyc);
    e = exp_rsp_q.pop_front();
    n_tests++;
    if (!got || {rd, er} !== e) begin
      $display("FAIL b2b_first: valid/rdata/err=%0b/%h/%b required 1/%h/%b", got, rd, er,
               e.rdata, e.err);
      n_fail++;
    end
    // Second request presented while the first response is on the bus; req_valid stays high.
    req_rd = 1'b0; req_dev_addr = d2; req_reg_addr = r2; req_wdata = w2; slave_rdata = s2;
    push_cmds(1'b0, d2, r2, w2);
    exp_rsp_q.push_back(rsp_t'({8'h00, 2'b00}));
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin
      $display("FAIL b2b_ready: req_ready=%0b required 1", req_ready); n_fail++;
    end
    @(negedge clk);
    n_tests++;
    if ({ack_err_clr, st_trigger} !== 2'b11) begin
      $display("FAIL b2b_accept: clr/trig=%b required 11", {ack_err_clr, st_trigger}); n_fail++;
    end
    req_valid = 1'b0;
    wait_rsp(400, got, rd, er, trig, cyc);
    e = exp_rsp_q.pop_front();
    n_tests++;
    if (!got || {rd, er} !== e) begin
      $display("FAIL b2b_second: valid/rdata/err=%0b/%h/%b required 1/%h/%b", got, rd, er,
               e.rdata, e.err);
      n_fail++;
    end
    while (exp_cmd_q.size() > 0) begin
      ec = exp_cmd_q.pop_front(); gc = 16'hxxxx;
      if (got_cmd_q.size() > 0) gc = got_cmd_q.pop_front();
      n_tests++;
      if (gc !== ec) begin $display("FAIL b2b_cmd: wr_data_in=%h required %h", gc, ec); n_fail++; end
    end
    n_tests++;
    if (got_cmd_q.size() != 0) begin
      $display("FAIL b2b_extra_cmds: count=%0d required 0", got_cmd_q.size()); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded 500000 time units");
    $fatal(1, "global timeout");
  end

endmodule
